// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Holds the FSM state encoding and the stream-format helpers.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    // Bytes of word-count header that precede the image data.
    localparam int HDR_LEN = 2;

    function automatic int bytes_per_word(input int instr_w);
        return (instr_w + 7) / 8;
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Collects stream bytes MSB-first into one instruction word.
// The word output already includes the byte presented on data, so it can be registered on the final transfer.
module byte_assembler #(
    parameter int INSTR_W = 20,
    parameter int BYTES   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift_en,
    input  logic               clear,
    input  logic [7:0]         data,
    output logic [INSTR_W-1:0] word,
    output logic               last_byte
);

    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [CNT_W-1:0] cnt;

    assign last_byte = (cnt == CNT_W'(BYTES - 1));

    generate
        if (INSTR_W > 8) begin : g_wide
            // Only INSTR_W-8 earlier bits are kept: anything older falls off the top,
            // which is exactly the excess of the first byte that must be discarded.
            logic [INSTR_W-9:0] shift;

            assign word = {shift, data};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    // NOTE: state registers take non-blocking assignments so every
                    // flop samples its inputs from before the edge.
                    shift <= '0;
                end else if (clear) begin
                    shift <= '0;
                end else if (shift_en) begin
                    shift <= word[INSTR_W-9:0];
                end
            end
        end else begin : g_narrow
            assign word = data[INSTR_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (shift_en) begin
            cnt <= last_byte ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: parses a count-prefixed byte stream, writes words
// into instruction memory from address 0 and holds the CPU in reset until done.
module prog_loader
    import loader_pkg::*;
#(
    parameter int INSTR_W = 20,
    parameter int ADDR_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_rst,
    output logic               done,
    output logic               err
);

    localparam int BYTES_PER_WORD = bytes_per_word(INSTR_W);
    localparam int DEPTH          = 1 << ADDR_W;

    state_t state, state_d;

    logic [15:0]        count;
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] word;
    logic               last_byte;
    logic               xfer;
    logic [15:0]        count_full;
    logic               count_bad;
    logic               last_word;

    logic shift_en, asm_clear, load_hi, load_lo, addr_clr, addr_inc;

    byte_assembler #(
        .INSTR_W (INSTR_W),
        .BYTES   (BYTES_PER_WORD)
    ) u_asm (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (shift_en),
        .clear     (asm_clear),
        .data      (in_data),
        .word      (word),
        .last_byte (last_byte)
    );

    assign in_ready   = (state == HDR_HI) || (state == HDR_LO) || (state == DATA);
    assign xfer       = in_valid && in_ready;
    assign count_full = {count[15:8], in_data};
    assign count_bad  = (count_full == 16'd0) || (17'(count_full) > 17'(DEPTH));
    assign last_word  = (16'(addr) == count - 16'd1);

    assign cpu_rst = (state != DONE);
    assign done    = (state == DONE);
    assign err     = (state == ERR);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d   = state;
        shift_en  = 1'b0;
        asm_clear = 1'b0;
        load_hi   = 1'b0;
        load_lo   = 1'b0;
        addr_clr  = 1'b0;
        addr_inc  = 1'b0;
        case (state)
            IDLE: if (start) state_d = HDR_HI;
            HDR_HI: begin
                if (xfer) begin
                    load_hi = 1'b1;
                    state_d = HDR_LO;
                end
            end
            HDR_LO: begin
                if (xfer) begin
                    load_lo = 1'b1;
                    if (count_bad) begin
                        state_d = ERR;
                    end else begin
                        addr_clr  = 1'b1;
                        asm_clear = 1'b1;
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    shift_en = 1'b1;
                    if (last_byte) state_d = WRITE;
                end
            end
            WRITE: begin
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    addr_inc  = 1'b1;
                    asm_clear = 1'b1;
                    state_d   = DATA;
                end
            end
            DONE: begin
                if (start) begin
                    addr_clr = 1'b1;
                    state_d  = HDR_HI;
                end
            end
            ERR:     if (start) state_d = HDR_HI;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            addr       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            state   <= state_d;
            imem_we <= (state_d == WRITE);
            if (load_hi) count[15:8] <= in_data;
            if (load_lo) count[7:0]  <= in_data;
            if (addr_clr) begin
                addr <= '0;
            end else if (addr_inc) begin
                addr <= addr + 1'b1;
            end
            // The memory port is loaded on the final byte so the strobe lands in the WRITE cycle.
            if (state_d == WRITE) begin
                imem_addr  <= addr;
                imem_wdata <= word;
            end
        end
    end

endmodule
